bus_decoder: RTL and testbench

Parametrised, registered address decoder and slave-select controller for the bexkat1 system bus, replacing the fixed combinational memory map. It decodes each master request against a table of NSLAVE base/mask regions and drives a registered one-hot slave select. It returns the selected slave's acknowledge to the master. It generates a bus error for unmapped addresses and for slaves that fail to acknowledge within TIMEOUT cycles, and latches the first faulting address for the CPU exception handler.

---
 rtl/bus_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_bus_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_decoder.sv
// Registered address decoder and slave-select controller for the bexkat1 bus.
// Decodes master requests against base/mask regions, times out silent slaves, records the first fault.
module bus_decoder #(
  parameter int AW      = 32,
  parameter int NSLAVE  = 4,
  // Element i lives at bits [i*AW +: AW]: slave 0 is the low-memory region, slave 3 the top region.
  parameter logic [NSLAVE*AW-1:0] BASE = {32'hffc00000, 32'hfe000000, 32'h00800000, 32'h00000000},
  parameter logic [NSLAVE*AW-1:0] MASK = {32'hffc00000, 32'hffc00000, 32'hff800000, 32'hfff80000},
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [AW-1:0]     adr_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [NSLAVE-1:0] sel_o,
  input  logic [NSLAVE-1:0] ack_i,
  output logic              fault_valid_o,
  output logic [AW-1:0]     fault_addr_o,
  output logic [1:0]        fault_code_o,
  input  logic              fault_clr_i
);

  localparam int            CW           = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN        = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST     = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
  localparam logic [1:0]    CODE_NONE    = 2'b00;
  localparam logic [1:0]    CODE_DECODE  = 2'b01;
  localparam logic [1:0]    CODE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } state_t;

  // Lowest matching region wins; an all-zero result means the address is unmapped.
  function automatic logic [NSLAVE-1:0] decode_onehot(input logic [AW-1:0] adr);
    logic [NSLAVE-1:0] oh;
    logic              found;
    logic              hit;
    oh    = {NSLAVE{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      hit   = ((adr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]);
      oh[i] = hit & ~found;
      found = found | hit;
    end
    return oh;
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic [NSLAVE-1:0] sel_r;
  logic [NSLAVE-1:0] sel_nx_s;
  logic              ack_r;
  logic              ack_nx_s;
  logic              err_r;
  logic              err_nx_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nx_s;
  logic              fault_valid_r;
  logic [AW-1:0]     fault_addr_r;
  logic [1:0]        fault_code_r;
  logic              fault_ev_s;
  logic [1:0]        fault_code_ev_s;
  logic              capture_s;

  logic              req_s;
  logic [NSLAVE-1:0] hit_oh_s;
  logic              hit_s;
  logic              sel_ack_s;
  logic              to_hit_s;

  assign req_s     = cyc_i & stb_i;
  assign hit_oh_s  = decode_onehot(adr_i);
  assign hit_s     = |hit_oh_s;
  assign sel_ack_s = |(ack_i & sel_r);
  assign to_hit_s  = TO_EN && (cnt_r == CNT_LAST);
  // A fresh fault overrides a same-cycle clear so it is never lost.
  assign capture_s = fault_ev_s & (~fault_valid_r | fault_clr_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            state_nx_s = ACTIVE;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!cyc_i) begin
          state_nx_s = IDLE;
        end else if (sel_ack_s || to_hit_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ACTIVE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and fault event.
  always_comb begin
    sel_nx_s        = {NSLAVE{1'b0}};
    ack_nx_s        = 1'b0;
    err_nx_s        = 1'b0;
    cnt_nx_s        = {CW{1'b0}};
    fault_ev_s      = 1'b0;
    fault_code_ev_s = CODE_NONE;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            sel_nx_s = hit_oh_s;
          end else begin
            err_nx_s        = 1'b1;
            fault_ev_s      = 1'b1;
            fault_code_ev_s = CODE_DECODE;
          end
        end else begin
          sel_nx_s = {NSLAVE{1'b0}};
        end
      end
      ACTIVE: begin
        if (!cyc_i) begin
          sel_nx_s = {NSLAVE{1'b0}};
        end else if (sel_ack_s) begin
          ack_nx_s = 1'b1;
        end else if (to_hit_s) begin
          err_nx_s        = 1'b1;
          fault_ev_s      = 1'b1;
          fault_code_ev_s = CODE_TIMEOUT;
        end else begin
          sel_nx_s = sel_r;
          cnt_nx_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
        end
      end
      DONE: begin
        sel_nx_s = {NSLAVE{1'b0}};
      end
      default: begin
        sel_nx_s = {NSLAVE{1'b0}};
      end
    endcase
  end

  // Registered bus-side outputs and timeout counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_r <= {NSLAVE{1'b0}};
      ack_r <= 1'b0;
      err_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else begin
      sel_r <= sel_nx_s;
      ack_r <= ack_nx_s;
      err_r <= err_nx_s;
      cnt_r <= cnt_nx_s;
    end
  end

  // Fault record: holds the first fault until software clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_valid_r <= 1'b0;
      fault_addr_r  <= {AW{1'b0}};
      fault_code_r  <= CODE_NONE;
    end else if (capture_s) begin
      fault_valid_r <= 1'b1;
      fault_addr_r  <= adr_i;
      fault_code_r  <= fault_code_ev_s;
    end else if (fault_clr_i) begin
      fault_valid_r <= 1'b0;
    end else begin
      fault_valid_r <= fault_valid_r;
    end
  end

  assign sel_o         = sel_r;
  assign ack_o         = ack_r;
  assign err_o         = err_r;
  assign fault_valid_o = fault_valid_r;
  assign fault_addr_o  = fault_addr_r;
  assign fault_code_o  = fault_code_r;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: default map with TIMEOUT=4, plus an overlapping-region instance.
module tb_bus_decoder;

  logic        clk;
  logic        rst;
  logic        cyc, stb, clr;
  logic [31:0] adr;
  logic [3:0]  ack_in;
  logic        ack_out, err_out, fv;
  logic [3:0]  sel;
  logic [31:0] fa;
  logic [1:0]  fc;

  logic        cyc_b, stb_b, clr_b;
  logic [31:0] adr_b;
  logic [3:0]  ack_in_b;
  logic        ack_out_b, err_out_b, fv_b;
  logic [3:0]  sel_b;
  logic [31:0] fa_b;
  logic [1:0]  fc_b;

  int n_checks = 0;
  int n_fail   = 0;

  bus_decoder #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
    .ack_o(ack_out), .err_o(err_out), .sel_o(sel), .ack_i(ack_in),
    .fault_valid_o(fv), .fault_addr_o(fa), .fault_code_o(fc), .fault_clr_i(clr)
  );

  // Regions 0 and 3 both cover the whole address space.
  bus_decoder #(
    .TIMEOUT(4),
    .BASE({32'h00000000, 32'hfe000000, 32'h00800000, 32'h00000000}),
    .MASK({32'h00000000, 32'hffc00000, 32'hff800000, 32'h00000000})
  ) dut_ov (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_b), .stb_i(stb_b), .adr_i(adr_b),
    .ack_o(ack_out_b), .err_o(err_out_b), .sel_o(sel_b), .ack_i(ack_in_b),
    .fault_valid_o(fv_b), .fault_addr_o(fa_b), .fault_code_o(fc_b), .fault_clr_i(clr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    cyc = 1'b1;
    stb = 1'b1;
    adr = a;
  endtask

  task automatic idle_bus();
    cyc    = 1'b0;
    stb    = 1'b0;
    ack_in = 4'b0000;
    clr    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; clr = 1'b0; adr = 32'h0; ack_in = 4'b0000;
    cyc_b = 1'b0; stb_b = 1'b0; clr_b = 1'b0; adr_b = 32'h0; ack_in_b = 4'b0000;
    repeat (3) step();
    check_eq("rst_sel", sel, 4'b0000);
    check_eq("rst_ack", ack_out, 1'b0);
    check_eq("rst_err", err_out, 1'b0);
    check_eq("rst_fv", fv, 1'b0);
    check_eq("rst_fa", fa, 32'h0);
    check_eq("rst_fc", fc, 2'b00);
    rst = 1'b0;
    step();

    // Hit on slave 1, ack one cycle after select
    req(32'h00801000);
    step();
    check_eq("hit_sel_n1", sel, 4'b0010);
    check_eq("hit_ack_n1", ack_out, 1'b0);
    check_eq("hit_err_n1", err_out, 1'b0);
    step();
    check_eq("hit_sel_n2", sel, 4'b0010);
    check_eq("hit_ack_n2", ack_out, 1'b0);
    ack_in = 4'b0010;
    step();
    check_eq("hit_ack_n3", ack_out, 1'b1);
    check_eq("hit_sel_n3", sel, 4'b0000);
    check_eq("hit_err_n3", err_out, 1'b0);
    idle_bus();
    step();
    check_eq("hit_ack_pulse", ack_out, 1'b0);
    check_eq("hit_err_after", err_out, 1'b0);

    // Decode fault, then a second fault that must not overwrite the record
    req(32'h40000000);
    step();
    check_eq("dec1_err", err_out, 1'b1);
    check_eq("dec1_sel", sel, 4'b0000);
    check_eq("dec1_fv", fv, 1'b1);
    check_eq("dec1_fa", fa, 32'h40000000);
    check_eq("dec1_fc", fc, 2'b01);
    idle_bus();
    step();
    check_eq("dec1_err_pulse", err_out, 1'b0);
    req(32'h50000000);
    step();
    check_eq("dec2_err", err_out, 1'b1);
    check_eq("dec2_fa_held", fa, 32'h40000000);
    check_eq("dec2_fc_held", fc, 2'b01);
    idle_bus();
    step();
    check_eq("dec2_err_pulse", err_out, 1'b0);

    // Clear colliding with a new decode fault, then clear alone
    req(32'h60000000);
    clr = 1'b1;
    step();
    check_eq("coll_fv", fv, 1'b1);
    check_eq("coll_fa", fa, 32'h60000000);
    idle_bus();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_fv", fv, 1'b0);
    check_eq("clr_fa_held", fa, 32'h60000000);

    // Timeout with no acknowledge
    req(32'hfe000010);
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq("to_sel_hold", sel, 4'b0100);
      check_eq("to_err_early", err_out, 1'b0);
      step();
    end
    check_eq("to_err", err_out, 1'b1);
    check_eq("to_sel_clr", sel, 4'b0000);
    check_eq("to_fv", fv, 1'b1);
    check_eq("to_fc", fc, 2'b10);
    check_eq("to_fa", fa, 32'hfe000010);
    idle_bus();
    step();
    check_eq("to_err_pulse", err_out, 1'b0);

    // Ack in the last accepted cycle beats the timeout
    req(32'hfe000010);
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq("tol_sel_hold", sel, 4'b0100);
      if (k == 3) ack_in = 4'b0100;
      step();
    end
    check_eq("tol_ack", ack_out, 1'b1);
    check_eq("tol_err", err_out, 1'b0);
    idle_bus();
    step();
    check_eq("tol_ack_pulse", ack_out, 1'b0);
    check_eq("tol_err_after", err_out, 1'b0);

    // Abort by dropping cyc, then an immediate new request
    req(32'h00001000);
    step();
    check_eq("ab_sel", sel, 4'b0001);
    step();
    cyc = 1'b0;
    stb = 1'b0;
    step();
    check_eq("ab_sel_clr", sel, 4'b0000);
    check_eq("ab_ack", ack_out, 1'b0);
    check_eq("ab_err", err_out, 1'b0);
    req(32'h00801000);
    step();
    check_eq("ab_new_sel", sel, 4'b0010);
    ack_in = 4'b0010;
    step();
    check_eq("ab_new_ack", ack_out, 1'b1);
    idle_bus();
    step();

    // Reset in the middle of a transfer (fault record is still held here)
    req(32'h00801000);
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("mrst_sel", sel, 4'b0000);
    check_eq("mrst_ack", ack_out, 1'b0);
    check_eq("mrst_err", err_out, 1'b0);
    check_eq("mrst_fv", fv, 1'b0);
    check_eq("mrst_fa", fa, 32'h0);
    check_eq("mrst_fc", fc, 2'b00);
    rst = 1'b0;
    idle_bus();
    step();

    // Overlapping regions: lowest index wins, other slaves' acks ignored
    cyc_b = 1'b1;
    stb_b = 1'b1;
    adr_b = 32'h12345678;
    step();
    check_eq("ov_sel", sel_b, 4'b0001);
    ack_in_b = 4'b1000;
    step();
    check_eq("ov_foreign_ack", ack_out_b, 1'b0);
    check_eq("ov_sel_hold", sel_b, 4'b0001);
    ack_in_b = 4'b0001;
    step();
    check_eq("ov_ack", ack_out_b, 1'b1);
    check_eq("ov_sel_clr", sel_b, 4'b0000);
    cyc_b = 1'b0;
    stb_b = 1'b0;
    ack_in_b = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
